// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage between AGEX and WB. Accepts one instruction at a time from
//   AGEX, performs data-memory loads/stores over a variable-latency req/ack
//   port, and produces the per-cycle MEM latch consumed by WB. Load data is
//   lane-aligned and sign/zero-extended into wb_regval. AGEX is stalled
//   (agex_ready=0) while an access is outstanding; WB never back-pressures.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   Defined: misaligned LH/LHU/SH/LW/SW do not access memory. They retire
//     immediately with wb_misalign=1 and wb_regval=0.
//   Undefined: no check; low address bits are used only for lane selection
//     and wb_misalign is tied 0.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   agex_*              instruction from AGEX, valid/ready handshake
//   dmem_*              data-memory request port (req held until ack)
//   wb_*                MEM latch fields to WB, wb_misalign flag
module mem_access_stage #(
  parameter int DBITS    = 32,
  parameter int INSTBITS = 32,
  parameter int TYPEBITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  // AGEX side
  input  logic                agex_valid,
  output logic                agex_ready,
  input  logic [3:0]          agex_mem_op,
  input  logic [DBITS-1:0]    agex_addr,
  input  logic [DBITS-1:0]    agex_wdata,
  input  logic [DBITS-1:0]    agex_alu,
  input  logic [INSTBITS-1:0] agex_inst,
  input  logic [DBITS-1:0]    agex_pc,
  input  logic [DBITS-1:0]    agex_inst_count,
  input  logic [TYPEBITS-1:0] agex_type,
  // Data memory
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DBITS-1:0]    dmem_addr,
  output logic [DBITS-1:0]    dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [DBITS-1:0]    dmem_rdata,
  // MEM latch to WB
  output logic                wb_valid,
  output logic [INSTBITS-1:0] wb_inst,
  output logic [DBITS-1:0]    wb_pc,
  output logic [TYPEBITS-1:0] wb_type,
  output logic [DBITS-1:0]    wb_inst_count,
  output logic [DBITS-1:0]    wb_regval,
  output logic                wb_misalign
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state, state_nxt;

  // Pending access context, held while BUSY and used at completion.
  mem_op_e             pend_op;
  logic [1:0]          pend_lane;
  logic [INSTBITS-1:0] pend_inst;
  logic [DBITS-1:0]    pend_pc;
  logic [DBITS-1:0]    pend_inst_count;
  logic [TYPEBITS-1:0] pend_type;

  logic             transfer;
  logic             is_mem;
  logic             is_store;
  logic             misalign;
  logic             start_mem;
  logic             retire_direct;
  logic             complete;
  logic [3:0]       be_c;
  logic [DBITS-1:0] wdata_c;
  logic [DBITS-1:0] load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // agex_ready depends only on reset and registered state, never on dmem_ack.
  assign agex_ready = reset & (state == IDLE);
  assign dmem_req   = (state == BUSY);
  assign transfer   = agex_valid & agex_ready;
  assign complete   = (state == BUSY) & dmem_ack;

  // Opcode decode; 9-15 fall into the defaults and behave as NONE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    is_mem   = 1'b0;
    is_store = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = agex_wdata;
    case (agex_mem_op)
      OP_LB, OP_LBU: begin
        is_mem = 1'b1;
        be_c   = 4'b0001 << agex_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_mem = 1'b1;
        be_c   = agex_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: is_mem = 1'b1;
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        be_c     = 4'b0001 << agex_addr[1:0];
        wdata_c  = {(DBITS/8){agex_wdata[7:0]}};
      end
      OP_SH: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        be_c     = agex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {(DBITS/16){agex_wdata[15:0]}};
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (agex_mem_op)
      OP_LH, OP_LHU, OP_SH: misalign = agex_addr[0];
      OP_LW, OP_SW:         misalign = |agex_addr[1:0];
      default: ;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Misaligned accesses retire straight from IDLE like a NONE op.
  assign start_mem     = transfer & is_mem & ~misalign;
  assign retire_direct = transfer & (~is_mem | misalign);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_mem) state_nxt = BUSY;
      BUSY: if (dmem_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request registers: loaded once at transfer, so they stay stable for the
  // whole time dmem_req is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_be         <= 4'b0000;
      pend_op         <= OP_NONE;
      pend_lane       <= 2'b00;
      pend_inst       <= '0;
      pend_pc         <= '0;
      pend_inst_count <= '0;
      pend_type       <= '0;
    end else if (start_mem) begin
      dmem_we         <= is_store;
      dmem_addr       <= {agex_addr[DBITS-1:2], 2'b00};
      dmem_wdata      <= wdata_c;
      dmem_be         <= be_c;
      pend_op         <= mem_op_e'(agex_mem_op);
      pend_lane       <= agex_addr[1:0];
      pend_inst       <= agex_inst;
      pend_pc         <= agex_pc;
      pend_inst_count <= agex_inst_count;
      pend_type       <= agex_type;
    end
  end

  // Load alignment and extension; stores and NONE produce 0.
  assign byte_sel = dmem_rdata[{pend_lane, 3'b000} +: 8];
  assign half_sel = pend_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_val = '0;
    case (pend_op)
      OP_LB:  load_val = {{(DBITS-8){byte_sel[7]}}, byte_sel};
      OP_LBU: load_val = {{(DBITS-8){1'b0}}, byte_sel};
      OP_LH:  load_val = {{(DBITS-16){half_sel[15]}}, half_sel};
      OP_LHU: load_val = {{(DBITS-16){1'b0}}, half_sel};
      OP_LW:  load_val = dmem_rdata;
      default: ;
    endcase
  end

  // MEM latch: wb_valid is a one-cycle pulse per retirement; data fields
  // hold their last value across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      wb_inst       <= '0;
      wb_pc         <= '0;
      wb_type       <= '0;
      wb_inst_count <= '0;
      wb_regval     <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (retire_direct) begin
        wb_valid      <= 1'b1;
        wb_inst       <= agex_inst;
        wb_pc         <= agex_pc;
        wb_type       <= agex_type;
        wb_inst_count <= agex_inst_count;
        wb_regval     <= misalign ? '0 : agex_alu;
      end else if (complete) begin
        wb_valid      <= 1'b1;
        wb_inst       <= pend_inst;
        wb_pc         <= pend_pc;
        wb_type       <= pend_type;
        wb_inst_count <= pend_inst_count;
        wb_regval     <= load_val;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              wb_misalign <= 1'b0;
    else if (retire_direct)  wb_misalign <= misalign;
    else if (complete)       wb_misalign <= 1'b0;
  end
`else
  assign wb_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Directed self-checking bench for mem_access_stage. Inputs change and
//   outputs are sampled on the falling clock edge; the DUT acts on the rising
//   edge. Each scenario task drives its own stimulus and compares inline.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        agex_valid;
  logic        agex_ready;
  logic [3:0]  agex_mem_op;
  logic [31:0] agex_addr;
  logic [31:0] agex_wdata;
  logic [31:0] agex_alu;
  logic [31:0] agex_inst;
  logic [31:0] agex_pc;
  logic [31:0] agex_inst_count;
  logic [2:0]  agex_type;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [31:0] wb_pc;
  logic [2:0]  wb_type;
  logic [31:0] wb_inst_count;
  logic [31:0] wb_regval;
  logic        wb_misalign;

  int passed = 0;
  int total  = 0;

  mem_access_stage #(.DBITS(32), .INSTBITS(32), .TYPEBITS(3)) dut (
    .clk(clk), .reset(reset),
    .agex_valid(agex_valid), .agex_ready(agex_ready),
    .agex_mem_op(agex_mem_op), .agex_addr(agex_addr),
    .agex_wdata(agex_wdata), .agex_alu(agex_alu),
    .agex_inst(agex_inst), .agex_pc(agex_pc),
    .agex_inst_count(agex_inst_count), .agex_type(agex_type),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc),
    .wb_type(wb_type), .wb_inst_count(wb_inst_count),
    .wb_regval(wb_regval), .wb_misalign(wb_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

  // Presents one instruction for one rising edge; called at a falling edge
  // while agex_ready is 1, returns at the falling edge after the transfer.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] alu);
    agex_valid      = 1'b1;
    agex_mem_op     = op;
    agex_addr       = addr;
    agex_wdata      = wdata;
    agex_alu        = alu;
    agex_pc         = alu ^ 32'h0000_F000;
    agex_inst       = alu + 32'd7;
    agex_inst_count = alu + 32'd1;
    agex_type       = alu[2:0];
    @(negedge clk);
    agex_valid = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] rdata);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (agex_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", agex_ready); else passed++;
    total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'b0)
      $display("FAIL rst_dmem_ctl: got req=%b we=%b be=%b exp 0/0/0", dmem_req, dmem_we, dmem_be); else passed++;
    total++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0)
      $display("FAIL rst_dmem_data: got addr=%h wdata=%h exp 0/0", dmem_addr, dmem_wdata); else passed++;
    total++; if (wb_valid !== 1'b0 || wb_misalign !== 1'b0 || wb_regval !== 32'h0 || wb_pc !== 32'h0)
      $display("FAIL rst_wb: got v=%b m=%b rv=%h pc=%h exp all 0", wb_valid, wb_misalign, wb_regval, wb_pc); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (agex_ready !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", agex_ready); else passed++;
  endtask

  task automatic test_none_back_to_back;
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    agex_valid  = 1'b1;
    agex_mem_op = 4'd0;
    for (int i = 0; i < 3; i++) begin
      agex_alu = vals[i];
      agex_pc  = 32'h100 + 32'(i);
      @(negedge clk);
      total++; if (wb_valid !== 1'b1 || wb_regval !== vals[i])
        $display("FAIL none_b2b_%0d: got v=%b rv=%h exp 1/%h", i, wb_valid, wb_regval, vals[i]); else passed++;
      total++; if (agex_ready !== 1'b1 || wb_pc !== 32'h100 + 32'(i))
        $display("FAIL none_b2b_ready_pc_%0d: got rdy=%b pc=%h exp 1/%h", i, agex_ready, wb_pc, 32'h100 + 32'(i)); else passed++;
    end
    // Opcode 12 is treated as NONE.
    agex_mem_op = 4'd12;
    agex_alu    = 32'h44;
    @(negedge clk);
    agex_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_regval !== 32'h44 || dmem_req !== 1'b0)
      $display("FAIL none_op12: got v=%b rv=%h req=%b exp 1/44/0", wb_valid, wb_regval, dmem_req); else passed++;
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) $display("FAIL none_bubble: got %b exp 0", wb_valid); else passed++;
  endtask

  task automatic test_lb;
    int low_cycles = 0;
    issue(4'd1, 32'h0000_1003, 32'h0, 32'hCAFE_0000);
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h0000_1000)
      $display("FAIL lb_req: got req=%b we=%b addr=%h exp 1/0/00001000", dmem_req, dmem_we, dmem_addr); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (agex_ready === 1'b0) low_cycles++;
      if (i == 2) ack_with(32'h80FF_0000);
      else @(negedge clk);
    end
    total++; if (low_cycles != 3) $display("FAIL lb_ready_low: got %0d cycles exp 3", low_cycles); else passed++;
    total++; if (wb_valid !== 1'b1 || wb_regval !== 32'hFFFF_FF80)
      $display("FAIL lb_data: got v=%b rv=%h exp 1/ffffff80", wb_valid, wb_regval); else passed++;
    total++; if (agex_ready !== 1'b1 || dmem_req !== 1'b0 || wb_pc !== 32'hCAFE_F000)
      $display("FAIL lb_done: got rdy=%b req=%b pc=%h exp 1/0/cafef000", agex_ready, dmem_req, wb_pc); else passed++;
  endtask

  task automatic test_loads;
    logic [3:0]  ops   [5];
    logic [31:0] addrs [5];
    logic [31:0] rds   [5];
    logic [31:0] exps  [5];
    ops   = '{4'd5, 4'd2, 4'd3, 4'd4, 4'd2};
    addrs = '{32'h2002, 32'h5002, 32'h6000, 32'h7001, 32'h5000};
    rds   = '{32'h8001_1234, 32'h8001_1234, 32'hDEAD_BEEF, 32'h0000_9A00, 32'h0000_F234};
    exps  = '{32'h0000_8001, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_009A, 32'hFFFF_F234};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], addrs[i], 32'h0, 32'h0);
      total++; if (dmem_req !== 1'b1 || agex_ready !== 1'b0 || dmem_addr !== {addrs[i][31:2], 2'b00})
        $display("FAIL load_req_%0d: got req=%b rdy=%b addr=%h", i, dmem_req, agex_ready, dmem_addr); else passed++;
      ack_with(rds[i]);
      total++; if (wb_valid !== 1'b1 || wb_regval !== exps[i])
        $display("FAIL load_data_%0d: got v=%b rv=%h exp 1/%h", i, wb_valid, wb_regval, exps[i]); else passed++;
    end
  endtask

  task automatic test_sb;
    issue(4'd6, 32'h0000_3001, 32'h1234_56AB, 32'h0);
    for (int i = 0; i < 2; i++) begin
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b0010 ||
                   dmem_wdata !== 32'hABAB_ABAB || dmem_addr !== 32'h0000_3000)
        $display("FAIL sb_hold_%0d: got req=%b we=%b be=%b wd=%h addr=%h", i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      else passed++;
      // A NONE op offered while busy must be ignored.
      agex_valid  = (i == 0);
      agex_mem_op = 4'd0;
      agex_alu    = 32'h77;
      @(negedge clk);
    end
    agex_valid = 1'b0;
    total++; if (agex_ready !== 1'b0 || wb_valid !== 1'b0)
      $display("FAIL sb_busy: got rdy=%b v=%b exp 0/0", agex_ready, wb_valid); else passed++;
    ack_with(32'hFFFF_FFFF);
    total++; if (wb_valid !== 1'b1 || wb_regval !== 32'h0)
      $display("FAIL sb_done: got v=%b rv=%h exp 1/0", wb_valid, wb_regval); else passed++;
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) $display("FAIL sb_no_stray: got %b exp 0", wb_valid); else passed++;
  endtask

  task automatic test_sh;
    issue(4'd7, 32'h0000_8002, 32'hFFFF_1234, 32'h0);
    total++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'h1234_1234)
      $display("FAIL sh_req: got we=%b be=%b wd=%h exp 1/1100/12341234", dmem_we, dmem_be, dmem_wdata); else passed++;
    ack_with(32'h0);
    total++; if (wb_valid !== 1'b1 || wb_regval !== 32'h0)
      $display("FAIL sh_done: got v=%b rv=%h exp 1/0", wb_valid, wb_regval); else passed++;
  endtask

  task automatic test_sw_misalign;
    issue(4'd8, 32'h0000_4002, 32'h5566_7788, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (dmem_req !== 1'b0 || agex_ready !== 1'b1)
      $display("FAIL sw_mis_noreq: got req=%b rdy=%b exp 0/1", dmem_req, agex_ready); else passed++;
    total++; if (wb_valid !== 1'b1 || wb_misalign !== 1'b1 || wb_regval !== 32'h0)
      $display("FAIL sw_mis_wb: got v=%b m=%b rv=%h exp 1/1/0", wb_valid, wb_misalign, wb_regval); else passed++;
`else
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_4000 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h5566_7788)
      $display("FAIL sw_unchecked: got req=%b addr=%h be=%b wd=%h", dmem_req, dmem_addr, dmem_be, dmem_wdata); else passed++;
    ack_with(32'h0);
    total++; if (wb_valid !== 1'b1 || wb_misalign !== 1'b0)
      $display("FAIL sw_unchecked_done: got v=%b m=%b exp 1/0", wb_valid, wb_misalign); else passed++;
`endif
  endtask

  task automatic test_ack_idle;
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0 || agex_ready !== 1'b1 || dmem_req !== 1'b0)
      $display("FAIL ack_idle: got v=%b rdy=%b req=%b exp 0/1/0", wb_valid, agex_ready, dmem_req); else passed++;
  endtask

  task automatic test_reset_mid_access;
    issue(4'd3, 32'h0000_9000, 32'h0, 32'h0);
    total++; if (dmem_req !== 1'b1) $display("FAIL rmid_req: got %b exp 1", dmem_req); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || agex_ready !== 1'b0 || dmem_addr !== 32'h0)
      $display("FAIL rmid_async: got req=%b v=%b rdy=%b addr=%h exp 0/0/0/0", dmem_req, wb_valid, agex_ready, dmem_addr); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (agex_ready !== 1'b1 || dmem_req !== 1'b0)
      $display("FAIL rmid_release: got rdy=%b req=%b exp 1/0", agex_ready, dmem_req); else passed++;
    @(negedge clk);
    issue(4'd0, 32'h0, 32'h0, 32'h55);
    total++; if (wb_valid !== 1'b1 || wb_regval !== 32'h55)
      $display("FAIL rmid_recover: got v=%b rv=%h exp 1/55", wb_valid, wb_regval); else passed++;
  endtask

  initial begin
    reset           = 1'b0;
    agex_valid      = 1'b0;
    agex_mem_op     = 4'd0;
    agex_addr       = 32'h0;
    agex_wdata      = 32'h0;
    agex_alu        = 32'h0;
    agex_inst       = 32'h0;
    agex_pc         = 32'h0;
    agex_inst_count = 32'h0;
    agex_type       = 3'd0;
    dmem_ack        = 1'b0;
    dmem_rdata      = 32'h0;

    test_reset;
    test_none_back_to_back;
    test_lb;
    test_loads;
    test_sb;
    test_sh;
    test_sw_misalign;
    test_ack_idle;
    test_reset_mid_access;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
